// File: rtl/tf_8to512.sv
// Receive-side width converter: packs an 8-bit byte stream into 520-bit
// packet words plus one 112-bit metadata word per packet.
module tf_8to512 #(
   parameter int         MAX_PKT_LEN = 2047,
   parameter logic [3:0] PORT_ID     = 4'd0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   m_axis_rx_tdata,
   input  logic         m_axis_rx_tvalid,
   input  logic         m_axis_rx_tlast,
   input  logic         m_axis_rx_tuser,
   output logic         m_axis_rx_tready,
   output logic [519:0] TF_8to512_out,
   output logic         TF_8to512_out_wr,
   output logic [111:0] TF_8to512_out_valid,
   output logic         TF_8to512_out_valid_wr,
   input  logic         TF_8to512_in_alf,
   output logic [15:0]  pkt_in_cnt,
   output logic [31:0]  pktbyte_in_cnt
);

   localparam logic [10:0] MAX_LEN = 11'(MAX_PKT_LEN);

   typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

   state_t       state_q;
   logic [511:0] word_q;
   logic [5:0]   idx_q;
   logic [10:0]  len_q;
   logic         first_q;

   logic         acc;
   logic [5:0]   idx_c;
   logic [10:0]  len_c;
   logic         first_c;
   logic [511:0] word_c;
   logic         ovf;
   logic         fin;

   assign m_axis_rx_tready = !TF_8to512_in_alf;

   // A beat arriving in IDLE always starts a fresh word at byte 0.
   always_comb begin
      acc     = m_axis_rx_tvalid && m_axis_rx_tready;
      idx_c   = (state_q == IDLE) ? 6'd0 : idx_q;
      len_c   = (state_q == IDLE) ? 11'd1 : len_q + 11'd1;
      first_c = (state_q == IDLE) || first_q;
      word_c  = (idx_c == 6'd0) ? '0 : word_q;
      word_c[{~idx_c, 3'b000} +: 8] = m_axis_rx_tdata;
      ovf     = (len_c == MAX_LEN) && !m_axis_rx_tlast;
      fin     = m_axis_rx_tlast || ovf;
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q                <= IDLE;
         word_q                 <= '0;
         idx_q                  <= '0;
         len_q                  <= '0;
         first_q                <= 1'b0;
         TF_8to512_out          <= '0;
         TF_8to512_out_wr       <= 1'b0;
         TF_8to512_out_valid    <= '0;
         TF_8to512_out_valid_wr <= 1'b0;
         pkt_in_cnt             <= '0;
         pktbyte_in_cnt         <= '0;
      end else begin
         TF_8to512_out_wr       <= 1'b0;
         TF_8to512_out_valid_wr <= 1'b0;
         if (acc) begin
            pktbyte_in_cnt <= pktbyte_in_cnt + 32'd1;
            if (state_q == DISCARD) begin
               if (m_axis_rx_tlast) state_q <= IDLE;
            end else begin
               state_q <= RECV;
               word_q  <= word_c;
               len_q   <= len_c;
               idx_q   <= 6'(idx_c + 6'd1);
               first_q <= first_c;
               if (fin || idx_c == 6'd63) begin
                  TF_8to512_out_wr <= 1'b1;
                  TF_8to512_out    <= {first_c, fin, idx_c, word_c};
                  first_q          <= 1'b0;
               end
               // Overflow closes the packet early with the error bit forced.
               if (fin) begin
                  TF_8to512_out_valid_wr <= 1'b1;
                  TF_8to512_out_valid    <= {PORT_ID,
                     m_axis_rx_tlast ? m_axis_rx_tuser : 1'b1,
                     len_c, 96'd0};
                  pkt_in_cnt <= pkt_in_cnt + 16'd1;
                  idx_q      <= 6'd0;
                  state_q    <= m_axis_rx_tlast ? IDLE : DISCARD;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_tf_8to512.sv
// Self-checking bench for tf_8to512: directed and random packets compared
// against a packet-level model built from byte lists.
module tb_tf_8to512;

   localparam int MAXL = 100;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   tdata;
   logic         tvalid, tlast, tuser, tready;
   logic [519:0] out;
   logic         out_wr;
   logic [111:0] meta;
   logic         meta_wr;
   logic         alf;
   logic [15:0]  pcnt;
   logic [31:0]  bcnt;

   always #5 clk = ~clk;

   tf_8to512 #(.MAX_PKT_LEN(MAXL), .PORT_ID(4'd0)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .m_axis_rx_tdata        (tdata),
      .m_axis_rx_tvalid       (tvalid),
      .m_axis_rx_tlast        (tlast),
      .m_axis_rx_tuser        (tuser),
      .m_axis_rx_tready       (tready),
      .TF_8to512_out          (out),
      .TF_8to512_out_wr       (out_wr),
      .TF_8to512_out_valid    (meta),
      .TF_8to512_out_valid_wr (meta_wr),
      .TF_8to512_in_alf       (alf),
      .pkt_in_cnt             (pcnt),
      .pktbyte_in_cnt         (bcnt)
   );

   logic [519:0] got_w[$];
   logic [519:0] exp_w[$];
   logic [111:0] got_m[$];
   logic [111:0] exp_m[$];
   int tests = 0;
   int fails = 0;
   int exp_pkts = 0;
   int exp_bytes = 0;

   always @(negedge clk) begin
      if (out_wr) got_w.push_back(out);
      if (meta_wr) got_m.push_back(meta);
   end

   task automatic chk(input string tag, input logic [519:0] obs,
                      input logic [519:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected output for one packet, derived from its byte list.
   function automatic void model(input logic [7:0] b[$], input bit tu);
      int  n   = b.size();
      int  len = (n > MAXL) ? MAXL : n;
      bit  err = (n > MAXL) ? 1'b1 : tu;
      int  nw  = (len + 63) / 64;
      for (int w = 0; w < nw; w++) begin
         logic [519:0] x = '0;
         int cnt = (w == nw - 1) ? len - 64 * w : 64;
         x[519] = (w == 0);
         x[518] = (w == nw - 1);
         x[517:512] = 6'(cnt - 1);
         for (int k = 0; k < cnt; k++) x[511 - 8 * k -: 8] = b[64 * w + k];
         exp_w.push_back(x);
      end
      exp_m.push_back({4'd0, err, 11'(len), 96'd0});
      exp_pkts++;
   endfunction

   task automatic beat(input logic [7:0] d, input bit last, input bit tu);
      tvalid = 1'b1;
      tdata  = d;
      tlast  = last;
      tuser  = tu;
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      tlast  = 1'b0;
      exp_bytes++;
   endtask

   task automatic send_pkt(input int n, input bit tu, input int stall_at,
                           input bit gaps, input int pat);
      logic [7:0] b[$];
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = (pat >= 0) ? 8'(pat + i) : 8'($urandom);
         b.push_back(d);
         if (gaps && $urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
         end
         if (i == stall_at) begin
            alf    = 1'b1;
            tvalid = 1'b1;
            tdata  = d;
            tlast  = (i == n - 1);
            #1;
            for (int c = 0; c < 10; c++) begin
               chk($sformatf("tready_stall%0d", c), 520'(tready), 520'd0);
               @(posedge clk);
               #1;
            end
            alf = 1'b0;
         end
         beat(d, i == n - 1, tu);
      end
      model(b, tu);
   endtask

   task automatic check_all(input string tag);
      int nw, nm;
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_nwords"}, 520'(got_w.size()), 520'(exp_w.size()));
      chk({tag, "_nmeta"}, 520'(got_m.size()), 520'(exp_m.size()));
      nw = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
      nm = (got_m.size() < exp_m.size()) ? got_m.size() : exp_m.size();
      for (int i = 0; i < nw; i++)
         chk($sformatf("%s_word%0d", tag, i), got_w[i], exp_w[i]);
      for (int i = 0; i < nm; i++)
         chk($sformatf("%s_meta%0d", tag, i), 520'(got_m[i]), 520'(exp_m[i]));
      chk({tag, "_pkt_cnt"}, 520'(pcnt), 520'(16'(exp_pkts)));
      chk({tag, "_byte_cnt"}, 520'(bcnt), 520'(32'(exp_bytes)));
      got_w.delete();
      got_m.delete();
      exp_w.delete();
      exp_m.delete();
   endtask

   initial begin
      rst_n  = 1'b1;
      tdata  = '0;
      tvalid = 1'b0;
      tlast  = 1'b0;
      tuser  = 1'b0;
      alf    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", out, '0);
      chk("rst_out_wr", 520'(out_wr), 520'd0);
      chk("rst_meta", 520'(meta), 520'd0);
      chk("rst_meta_wr", 520'(meta_wr), 520'd0);
      chk("rst_pkt_cnt", 520'(pcnt), 520'd0);
      chk("rst_byte_cnt", 520'(bcnt), 520'd0);
      chk("rst_tready", 520'(tready), 520'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;

      send_pkt(64, 1'b0, -1, 1'b0, 0);
      check_all("p64");
      send_pkt(130, 1'b0, -1, 1'b0, -1);
      check_all("p130");
      send_pkt(1, 1'b0, -1, 1'b0, 8'hA5);
      send_pkt(2, 1'b0, -1, 1'b0, 8'hA5);
      check_all("b2b");
      send_pkt(60, 1'b1, -1, 1'b0, -1);
      check_all("tuser");
      send_pkt(150, 1'b0, -1, 1'b0, -1);
      check_all("ovf");
      send_pkt(100, 1'b1, -1, 1'b0, -1);
      check_all("exact_max");
      send_pkt(80, 1'b0, 20, 1'b0, -1);
      check_all("alf");

      for (int i = 0; i < 30; i++) beat(8'($urandom), 1'b0, 1'b0);
      #2;
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      exp_bytes = 0;
      exp_pkts  = 0;
      check_all("midrst");
      send_pkt(70, 1'b0, -1, 1'b0, -1);
      check_all("after_rst");

      for (int p = 0; p < 20; p++) begin
         send_pkt(int'($urandom_range(140, 1)), 1'($urandom),
                  ($urandom_range(3) == 0) ? int'($urandom_range(40)) : -1,
                  1'b1, -1);
         if ($urandom_range(1) == 0) check_all($sformatf("rnd%0d", p));
      end
      check_all("rnd_end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
